// File: rtl/exe_div_ctrl.sv
// exe_div_ctrl: multi-cycle radix-2 restoring divide sequencer for RV32M DIV/DIVU/REM/REMU.
// Ports: clk_in/reset_in (async, active-high); start_in, funct3_in, op1_in, op2_in, reg_waddr_in
// launch an operation; flush_in kills it; stall_out holds IF/ID/EX; busy_out is state != IDLE;
// done_out/reg_we_out pulse one cycle with reg_wdata_out/reg_waddr_out.
// Optional feature macro: DIV_EARLY_OUT_EN (finish immediately when |op1| < |op2|).
module exe_div_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int RADDR_WIDTH = 5
) (
   input  logic                   clk_in,
   input  logic                   reset_in,
   input  logic                   start_in,
   input  logic [2:0]             funct3_in,
   input  logic [DATA_WIDTH-1:0]  op1_in,
   input  logic [DATA_WIDTH-1:0]  op2_in,
   input  logic [RADDR_WIDTH-1:0] reg_waddr_in,
   input  logic                   flush_in,
   output logic                   stall_out,
   output logic                   busy_out,
   output logic                   done_out,
   output logic [DATA_WIDTH-1:0]  reg_wdata_out,
   output logic [RADDR_WIDTH-1:0] reg_waddr_out,
   output logic                   reg_we_out
);
   localparam int CW = $clog2(DATA_WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  quo_q, quo_d, rem_q, rem_d, div_q, div_d, wdata_q, wdata_d;
   logic [RADDR_WIDTH-1:0] rd_q, rd_d, waddr_q, waddr_d;
   logic                   is_rem_q, is_rem_d, qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;
   logic                   accept, s1, s2, early, geq, short_path;
   logic [DATA_WIDTH-1:0]  a1, a2;
   logic [DATA_WIDTH:0]    shifted, diff;
   assign accept = start_in & funct3_in[2] & ~flush_in;
   // funct3[0]=0 selects the signed forms
   assign s1 = ~funct3_in[0] & op1_in[DATA_WIDTH-1];
   assign s2 = ~funct3_in[0] & op2_in[DATA_WIDTH-1];
   assign a1 = s1 ? -op1_in : op1_in;
   assign a2 = s2 ? -op2_in : op2_in;
`ifdef DIV_EARLY_OUT_EN
   assign early = (a2 != '0) && (a1 < a2);
`else
   assign early = 1'b0;
`endif
   // x/0 and early-out skip CALC: quotient preloaded, remainder is |dividend|
   assign short_path = (a2 == '0) | early;
   assign shifted = {rem_q, quo_q[DATA_WIDTH-1]};
   assign diff = shifted - {1'b0, div_q};
   // shifted < 2*div, so the borrow bit is a correct compare result
   assign geq = ~diff[DATA_WIDTH];
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      div_d    = div_q;
      rd_d     = rd_q;
      is_rem_d = is_rem_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      wdata_d  = wdata_q;
      waddr_d  = waddr_q;
      done_d   = 1'b0;
      if (flush_in)
         state_d = IDLE;
      else
         case (state_q)
            IDLE: if (accept) begin
               state_d  = short_path ? DONE : CALC;
               cnt_d    = CW'(DATA_WIDTH - 1);
               quo_d    = (a2 == '0) ? '1 : early ? '0 : a1;
               rem_d    = short_path ? a1 : '0;
               div_d    = a2;
               rd_d     = reg_waddr_in;
               is_rem_d = funct3_in[1];
               qneg_d   = (s1 ^ s2) & (a2 != '0);
               rneg_d   = s1;
            end
            CALC: begin
               quo_d   = {quo_q[DATA_WIDTH-2:0], geq};
               rem_d   = geq ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
               cnt_d   = cnt_q - 1'b1;
               state_d = (cnt_q == '0) ? DONE : CALC;
            end
            DONE: begin
               done_d  = 1'b1;
               waddr_d = rd_q;
               wdata_d = is_rem_q ? (rneg_q ? -rem_q : rem_q) : (qneg_q ? -quo_q : quo_q);
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
   end
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         div_q    <= '0;
         rd_q     <= '0;
         is_rem_q <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         wdata_q  <= '0;
         waddr_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         div_q    <= div_d;
         rd_q     <= rd_d;
         is_rem_q <= is_rem_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         wdata_q  <= wdata_d;
         waddr_q  <= waddr_d;
         done_q   <= done_d;
      end
   end
   assign busy_out      = state_q != IDLE;
   assign stall_out     = ~reset_in & ((state_q == IDLE & accept) | state_q == CALC);
   assign done_out      = done_q;
   assign reg_we_out    = done_q;
   assign reg_wdata_out = wdata_q;
   assign reg_waddr_out = waddr_q;
endmodule

// File: tb/tb_exe_div_ctrl.sv
// tb_exe_div_ctrl: self-checking bench for exe_div_ctrl against an arithmetic reference model.
module tb_exe_div_ctrl;
   logic        clk_in = 1'b0, reset_in = 1'b1, start_in = 1'b0, flush_in = 1'b0;
   logic [2:0]  funct3_in = 3'b100;
   logic [31:0] op1_in = '0, op2_in = '0;
   logic [4:0]  reg_waddr_in = '0;
   logic        stall_out, busy_out, done_out, reg_we_out;
   logic [31:0] reg_wdata_out;
   logic [4:0]  reg_waddr_out;
`ifdef DIV_EARLY_OUT_EN
   localparam int EO = 1;
`else
   localparam int EO = 0;
`endif
   localparam int FULL = 34;
   localparam int SHORT = EO ? 2 : 34;
   int errors = 0, checks = 0;
   int cyc = 0, exp_at = 0, stall_cnt = 0;
   logic valid = 1'b0;
   logic [31:0] exp_data = '0, hold_d = '0;
   logic [4:0]  exp_rd = '0, hold_r = '0;
   logic ed, eb, es;
   exe_div_ctrl dut (
      .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .funct3_in(funct3_in),
      .op1_in(op1_in), .op2_in(op2_in), .reg_waddr_in(reg_waddr_in), .flush_in(flush_in),
      .stall_out(stall_out), .busy_out(busy_out), .done_out(done_out),
      .reg_wdata_out(reg_wdata_out), .reg_waddr_out(reg_waddr_out), .reg_we_out(reg_we_out)
   );
   always #5 clk_in = ~clk_in;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? 32'(-v) : v;
   endfunction
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic sgn = ~f3[0];
      if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : 32'h8000_0000;
      if (sgn) return f3[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      return f3[1] ? a % b : a / b;
   endfunction
   function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (b == 0) return 1;
      if (EO != 0 && mag(a, ~f3[0]) < mag(b, ~f3[0])) return 1;
      return 33;
   endfunction
   // reference model: tracks which edge a pending operation must report on
   always @(posedge clk_in or posedge reset_in) begin
      if (reset_in) valid = 1'b0;
      else begin
         cyc++;
         if (flush_in) begin
            if (valid && cyc <= exp_at) valid = 1'b0;
         end else if (start_in && funct3_in[2] && !(valid && cyc - 1 < exp_at)) begin
            valid = 1'b1;
            exp_at = cyc + lat_of(funct3_in, op1_in, op2_in);
            exp_data = model(funct3_in, op1_in, op2_in);
            exp_rd = reg_waddr_in;
         end
      end
   end
   always @(negedge clk_in) begin
      if (reset_in) begin
         hold_d = '0;
         hold_r = '0;
      end else if (valid && cyc == exp_at) begin
         hold_d = exp_data;
         hold_r = exp_rd;
      end
      ed = !reset_in && valid && cyc == exp_at;
      eb = !reset_in && valid && cyc < exp_at;
      es = !reset_in && ((valid && cyc < exp_at - 1) || (!eb && start_in && funct3_in[2] && !flush_in));
      if (stall_out) stall_cnt++;
      chk("done", 32'(done_out), 32'(ed));
      chk("we", 32'(reg_we_out), 32'(ed));
      chk("busy", 32'(busy_out), 32'(eb));
      chk("stall", 32'(stall_out), 32'(es));
      chk("wdata", reg_wdata_out, hold_d);
      chk("waddr", 32'(reg_waddr_out), 32'(hold_r));
   end
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask
   task automatic op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] want, input int edges);
      int n;
      funct3_in = f3;
      op1_in = a;
      op2_in = b;
      reg_waddr_in = rd;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      n = 1;
      while (!done_out && n < 100) begin
         tick();
         n++;
      end
      chk("edges", 32'(n), 32'(edges));
      chk("result", reg_wdata_out, want);
      chk("rd", 32'(reg_waddr_out), 32'(rd));
      tick();
   endtask
   initial begin
      #1;
      chk("rst_done", 32'(done_out), 32'h0);
      chk("rst_wdata", reg_wdata_out, 32'h0);
      tick();
      tick();
      reset_in = 1'b0;
      tick();
      stall_cnt = 0;
      op(3'b101, 32'd100, 32'd7, 5'd3, 32'd14, FULL);
      chk("stall_cycles", 32'(stall_cnt), 32'd33);
      op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, FULL);
      op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, FULL);
      op(3'b111, 32'd7, 32'hFFFF_FFFE, 5'd6, 32'd7, SHORT);
      op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, FULL);
      op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0, FULL);
      op(3'b101, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 2);
      op(3'b110, 32'd5, 32'd0, 5'd10, 32'd5, 2);
      op(3'b100, 32'hFFFF_FFF6, 32'd0, 5'd11, 32'hFFFF_FFFF, 2);
      op(3'b110, 32'hFFFF_FFF6, 32'd3, 5'd12, 32'hFFFF_FFFF, FULL);
      op(3'b101, 32'd3, 32'd9, 5'd13, 32'd0, SHORT);
      op(3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 5'd14, 32'd1, FULL);
      op(3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 5'd15, 32'h7FFF_FFFE, FULL);
      // flush at iteration 10
      funct3_in = 3'b101; op1_in = 32'd1000; op2_in = 32'd3; reg_waddr_in = 5'd20;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      repeat (10) tick();
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      chk("flush_busy", 32'(busy_out), 32'h0);
      begin
         int seen = 0;
         repeat (40) begin
            tick();
            if (done_out) seen++;
         end
         chk("flush_no_done", 32'(seen), 32'h0);
      end
      // flush beats start in IDLE
      start_in = 1'b1; flush_in = 1'b1;
      tick();
      start_in = 1'b0; flush_in = 1'b0;
      chk("flush_start_busy", 32'(busy_out), 32'h0);
      repeat (3) tick();
      // async reset mid-CALC
      funct3_in = 3'b100; op1_in = 32'd77; op2_in = 32'd5; reg_waddr_in = 5'd21;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      repeat (5) tick();
      #2 reset_in = 1'b1;
      #1;
      chk("arst_busy", 32'(busy_out), 32'h0);
      chk("arst_stall", 32'(stall_out), 32'h0);
      chk("arst_wdata", reg_wdata_out, 32'h0);
      chk("arst_waddr", 32'(reg_waddr_out), 32'h0);
      tick();
      reset_in = 1'b0;
      tick();
      op(3'b101, 32'd100, 32'd7, 5'd22, 32'd14, FULL);
      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
